// File: rtl/adc733_frame_scheduler.sv
// -----------------------------------------------------------------------------
// adc733_frame_scheduler
//
// Purpose:
//   Drives the adc733 wrapper in capture mode. A free-running period counter
//   produces a tick every PERIOD cycles; each tick seen while waiting issues a
//   one-cycle SYNC that starts a conversion. The per-channel samples returned
//   on RD_EN/DATA_O/CHANNEL are collected into a frame buffer. A complete
//   frame is offered downstream over a valid/ready handshake. Collection is
//   abandoned if the frame does not complete within TIMEOUT cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          1 = run scheduling, 0 = hold in IDLE
//   op_mode_i       wrapper OP_MODE (1 = data mode); run = enable & op_mode_i
//   rd_en_i         one-cycle sample strobe from the wrapper
//   data_i          sample value, qualified by rd_en_i
//   channel_i       sample channel index, qualified by rd_en_i
//   sync_o          one-cycle conversion start to the wrapper
//   frame_valid_o   frame_data_o holds a complete frame
//   frame_ready_i   consumer accepts the frame when high with frame_valid_o
//   frame_data_o    channel k at bits [k*DW +: DW]
//   timeout_o       one-cycle pulse: frame abandoned on timeout
//   chan_err_o      one-cycle pulse: unexpected/duplicate/out-of-range sample
//   overrun_cnt_o   ticks that could not start a conversion, saturating
// -----------------------------------------------------------------------------
module adc733_frame_scheduler #(
   parameter int NUM_CH  = 6,
   parameter int DW      = 16,
   parameter int PERIOD  = 16384,
   parameter int TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 op_mode_i,
   input  logic                 rd_en_i,
   input  logic [DW-1:0]        data_i,
   input  logic [2:0]           channel_i,
   output logic                 sync_o,
   output logic                 frame_valid_o,
   input  logic                 frame_ready_i,
   output logic [NUM_CH*DW-1:0] frame_data_o,
   output logic                 timeout_o,
   output logic                 chan_err_o,
   output logic [7:0]           overrun_cnt_o
);

   localparam int PW = $clog2(PERIOD);
   // +1 keeps the width at least one bit when TIMEOUT is 1.
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_COLLECT = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic [PW-1:0]               per_cnt_q, per_cnt_d;
   logic [TW-1:0]               tmo_cnt_q, tmo_cnt_d;
   logic [NUM_CH-1:0]           mask_q, mask_d;
   logic                        sync_q, sync_d;
   logic                        tmo_q, tmo_d;
   logic                        err_q, err_d;
   logic [7:0]                  ovr_q, ovr_d;
   logic [NUM_CH-1:0][DW-1:0]   slot_q, slot_d;

   logic              run;
   logic              tick;
   logic [NUM_CH-1:0] hit;
   logic              in_range;
   logic              dup;
   logic              accept;
   logic [NUM_CH-1:0] wr_en;

   assign run  = enable & op_mode_i;
   assign tick = run && (per_cnt_q == PW'(PERIOD - 1));

   // One-hot decode of the incoming channel; indices >= NUM_CH decode to zero.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
      assign hit[gi] = (channel_i == 3'(gi));
   end

   assign in_range = |hit;
   assign dup      = |(hit & mask_q);
   assign accept   = run && rd_en_i && (state_q == S_COLLECT) && in_range && !dup;
   assign wr_en    = accept ? hit : '0;

   always_comb begin
      per_cnt_d = '0;
      if (run) begin
         per_cnt_d = tick ? '0 : per_cnt_q + PW'(1);
      end
   end

   always_comb begin
      slot_d = slot_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (wr_en[k]) begin
            slot_d[k] = data_i;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      tmo_cnt_d = tmo_cnt_q;
      sync_d    = 1'b0;
      tmo_d     = 1'b0;
      err_d     = 1'b0;
      ovr_d     = ovr_q;
      if (!run) begin
         state_d   = S_IDLE;
         mask_d    = '0;
         tmo_cnt_d = '0;
      end else begin
         // Any tick that does not land in WAIT is a missed conversion slot,
         // including one coinciding with the consumer accepting a frame.
         if (tick && (state_q != S_WAIT) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
         end
         case (state_q)
            S_IDLE: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               err_d = rd_en_i;
               if (tick) begin
                  sync_d    = 1'b1;
                  mask_d    = '0;
                  tmo_cnt_d = '0;
                  state_d   = S_COLLECT;
               end
            end
            S_COLLECT: begin
               err_d  = rd_en_i && !accept;
               mask_d = mask_q | wr_en;
               // Completion is checked first so a last sample arriving on the
               // expiry cycle still yields a frame.
               if (&mask_d) begin
                  state_d = S_HOLD;
               end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                  tmo_d   = 1'b1;
                  state_d = S_WAIT;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TW'(1);
               end
            end
            default: begin
               err_d = rd_en_i;
               if (frame_ready_i) begin
                  state_d = S_WAIT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         per_cnt_q <= '0;
         tmo_cnt_q <= '0;
         mask_q    <= '0;
         sync_q    <= 1'b0;
         tmo_q     <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 8'd0;
         slot_q    <= '0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         mask_q    <= mask_d;
         sync_q    <= sync_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         ovr_q     <= ovr_d;
         slot_q    <= slot_d;
      end
   end

   assign sync_o        = sync_q;
   assign timeout_o     = tmo_q;
   assign chan_err_o    = err_q;
   assign overrun_cnt_o = ovr_q;
   assign frame_valid_o = (state_q == S_HOLD);
   assign frame_data_o  = slot_q;

endmodule
